// File: rtl/z80_prefetch_queue_if.sv
// z80_prefetch_queue_if: fetch bus and prefetch queue signals between core, memory and prefetcher
interface z80_prefetch_queue_if #(
   parameter int AW    = 16,
   parameter int DW    = 8,
   parameter int DEPTH = 4
);
   logic [AW-1:0]              A;
   logic                       RD;
   logic [DW-1:0]              DI;
   logic                       BUS_REQ;
   logic                       FLUSH;
   logic [AW-1:0]              FLUSH_PC;
   logic                       POP;
   logic [DW-1:0]              Q_DATA;
   logic [AW-1:0]              Q_PC;
   logic                       Q_VALID;
   logic [$clog2(DEPTH+1)-1:0] Q_LEVEL;
   modport master (output DI, BUS_REQ, FLUSH, FLUSH_PC, POP,
                   input  A, RD, Q_DATA, Q_PC, Q_VALID, Q_LEVEL);
   modport slave  (input  DI, BUS_REQ, FLUSH, FLUSH_PC, POP,
                   output A, RD, Q_DATA, Q_PC, Q_VALID, Q_LEVEL);
endinterface

// File: rtl/z80_prefetch_queue.sv
// z80_prefetch_queue: sequential opcode prefetcher with PC-tagged FIFO, flush and bus yield
module z80_prefetch_queue #(
   parameter int            AW       = 16,
   parameter int            DW       = 8,
   parameter int            DEPTH    = 4,
   parameter int            MEM_LAT  = 1,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input logic CLOCK,
   input logic RESET,
   z80_prefetch_queue_if.slave bus
);
   localparam int LW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam int IW = $clog2(MEM_LAT+1);
   localparam int SW = $clog2(DEPTH+MEM_LAT+1);
   logic [AW-1:0] fetch_pc;
   logic [DW-1:0] q_data [DEPTH];
   logic [AW-1:0] q_pc [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [LW-1:0] level;
   logic [IW-1:0] inflight;
   logic          tag_v [MEM_LAT];
   logic [AW-1:0] tag_pc [MEM_LAT];
   logic          issue, push, pop, valid;
   // credit check uses registered counts only, so a same-cycle pop never frees a slot early
   always_comb begin
      issue = !RESET && !bus.BUS_REQ && !bus.FLUSH
              && (SW'(level) + SW'(inflight) < SW'(DEPTH));
      push  = tag_v[MEM_LAT-1];
      valid = level != '0;
      pop   = bus.POP && valid;
   end
   assign bus.RD      = issue;
   assign bus.A       = fetch_pc;
   assign bus.Q_VALID = valid;
   assign bus.Q_LEVEL = level;
   assign bus.Q_DATA  = valid ? q_data[rp] : '0;
   assign bus.Q_PC    = valid ? q_pc[rp] : '0;
   // fetch address and in-flight tag pipeline; flush kills every outstanding read
   always_ff @(posedge CLOCK) begin
      if (RESET || bus.FLUSH) begin
         fetch_pc <= RESET ? RESET_PC : bus.FLUSH_PC;
         for (int i = 0; i < MEM_LAT; i++) tag_v[i] <= 1'b0;
         inflight <= '0;
      end else begin
         if (issue) fetch_pc <= fetch_pc + AW'(1);
         tag_v[0]  <= issue;
         tag_pc[0] <= fetch_pc;
         for (int i = 1; i < MEM_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_pc[i] <= tag_pc[i-1];
         end
         inflight <= inflight + IW'(issue) - IW'(push);
      end
   end
   // queue storage; returning byte lands at the tail tagged with its issue address
   always_ff @(posedge CLOCK) begin
      if (push) begin
         q_data[wp] <= bus.DI;
         q_pc[wp]   <= tag_pc[MEM_LAT-1];
      end
   end
   // queue pointers and fill level
   always_ff @(posedge CLOCK) begin
      if (RESET || bus.FLUSH) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   end
endmodule
